// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with registered results and a status-register
// style flag interface. Single-operand rotates, logic ops, add/sub with
// carry, compare/bit-test, and an optional iterative unsigned multiplier.
//
// Build option: define ALU_MC_MUL_EN to include the shift-add multiplier
// (MUL state, iteration counter, partial-product datapath). Without it,
// opcode 0xA behaves like the reserved opcodes and BUSY is tied low.
//
// Timing: a non-MUL op accepted on edge N shows DONE=1 with results valid
// in the cycle after edge N. A MUL spends WIDTH cycles in MUL (BUSY=1) and
// shows DONE in cycle WIDTH+1 after the accepting edge.

module alu_mc #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [3:0]       OP,
  input  logic [WIDTH-1:0] OP_X,
  input  logic [WIDTH-1:0] OP_Y,
  input  logic [15:0]      SR_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic [WIDTH-1:0] RES_HI,
  output logic [15:0]      SR_OUT
);

  // Opcode map
  localparam logic [3:0] OP_RRC  = 4'h0;
  localparam logic [3:0] OP_RRA  = 4'h1;
  localparam logic [3:0] OP_MOV  = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_ADDC = 4'h6;
  localparam logic [3:0] OP_SUBC = 4'h7;
  localparam logic [3:0] OP_SUB  = 4'h8;
  localparam logic [3:0] OP_CMP  = 4'h9;
  localparam logic [3:0] OP_BIT  = 4'hB;
  localparam logic [3:0] OP_BIC  = 4'hC;
  localparam logic [3:0] OP_BIS  = 4'hD;
  localparam logic [3:0] OP_XOR  = 4'hE;
  localparam logic [3:0] OP_AND  = 4'hF;
`ifdef ALU_MC_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'hA;
  localparam int         CNT_W   = $clog2(WIDTH);
`endif

  // Status-register flag bit positions
  localparam int SR_V = 8;
  localparam int SR_N = 2;
  localparam int SR_Z = 1;
  localparam int SR_C = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef ALU_MC_MUL_EN
    ST_MUL  = 2'd1,
`endif
    ST_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic accept;     // a request is taken this cycle
  logic alu_load;   // single-cycle op result is registered this edge
  logic mul_load;   // multiplier operands are captured this edge

  assign accept = START && ((state == ST_IDLE) || (state == ST_DONE));

`ifdef ALU_MC_MUL_EN
  assign mul_load = accept && (OP == OP_MUL);
`else
  assign mul_load = 1'b0;
`endif
  assign alu_load = accept && !mul_load;

  // ---------------------------------------------------------------------
  // Single-cycle datapath: shared adder plus result/flag selection
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] add_a, add_b;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic             add_v;

  // Adder operand selection: subtraction forms add the inverted X operand.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    add_a   = OP_Y;
    add_b   = OP_X;
    add_cin = 1'b0;
    case (OP)
      OP_ADDC: add_cin = SR_IN[SR_C];
      OP_SUBC: begin
        add_b   = ~OP_X;
        add_cin = SR_IN[SR_C];
      end
      OP_SUB, OP_CMP: begin
        add_b   = ~OP_X;
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  assign add_sum = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
  // Signed overflow: like-signed operands producing an opposite-signed sum.
  assign add_v   = (add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                   (add_sum[WIDTH-1] != add_a[WIDTH-1]);

  logic [WIDTH-1:0] res_val;   // value the N/Z flags are derived from
  logic [WIDTH-1:0] alu_out;   // value presented on DATA_OUT
  logic             new_v;
  logic             new_c;
  logic             upd_flags; // op rewrites V/N/Z/C
  logic [15:0]      alu_sr;

  // Result and flag selection for every single-cycle opcode.
  always_comb begin
    res_val   = '0;
    alu_out   = '0;
    new_v     = 1'b0;
    new_c     = 1'b0;
    upd_flags = 1'b0;
    case (OP)
      OP_RRC: begin
        res_val   = {SR_IN[SR_C], OP_Y[WIDTH-1:1]};
        alu_out   = res_val;
        new_c     = OP_Y[0];
        upd_flags = 1'b1;
      end
      OP_RRA: begin
        res_val   = {OP_Y[WIDTH-1], OP_Y[WIDTH-1:1]};
        alu_out   = res_val;
        new_c     = OP_Y[0];
        upd_flags = 1'b1;
      end
      OP_MOV: alu_out = OP_X;
      OP_BIC: alu_out = ~OP_X & OP_Y;
      OP_BIS: alu_out = OP_X | OP_Y;
      OP_ADD, OP_ADDC, OP_SUBC, OP_SUB: begin
        res_val   = add_sum[WIDTH-1:0];
        alu_out   = res_val;
        new_c     = add_sum[WIDTH];
        new_v     = add_v;
        upd_flags = 1'b1;
      end
      OP_CMP: begin
        // Flags as SUB, destination passes through unchanged.
        res_val   = add_sum[WIDTH-1:0];
        alu_out   = OP_Y;
        new_c     = add_sum[WIDTH];
        new_v     = add_v;
        upd_flags = 1'b1;
      end
      OP_XOR: begin
        res_val   = OP_X ^ OP_Y;
        alu_out   = res_val;
        new_v     = OP_X[WIDTH-1] & OP_Y[WIDTH-1];
        new_c     = |res_val;
        upd_flags = 1'b1;
      end
      OP_AND: begin
        res_val   = OP_X & OP_Y;
        alu_out   = res_val;
        new_c     = |res_val;
        upd_flags = 1'b1;
      end
      OP_BIT: begin
        // Flags as AND, destination passes through unchanged.
        res_val   = OP_X & OP_Y;
        alu_out   = OP_Y;
        new_c     = |res_val;
        upd_flags = 1'b1;
      end
      // Reserved opcodes (and MUL when the multiplier is not built) give
      // zero results with the status word passed straight through.
      default: ;
    endcase
  end

  // Merge updated flags into the incoming status word.
  always_comb begin
    alu_sr = SR_IN;
    if (upd_flags) begin
      alu_sr[SR_V] = new_v;
      alu_sr[SR_N] = res_val[WIDTH-1];
      alu_sr[SR_Z] = (res_val == '0);
      alu_sr[SR_C] = new_c;
    end
  end

  // ---------------------------------------------------------------------
  // Iterative multiplier: one partial product per MUL cycle
  // ---------------------------------------------------------------------
`ifdef ALU_MC_MUL_EN
  logic [WIDTH-1:0] mul_x;       // multiplicand
  logic [WIDTH-1:0] mul_hi;      // running upper half of the product
  logic [WIDTH-1:0] mul_lo;      // multiplier bits shifting out / product low half
  logic [15:0]      mul_sr;      // status word captured on accept
  logic [CNT_W-1:0] mul_cnt;
  logic [WIDTH:0]   mul_add;
  logic [WIDTH-1:0] mul_hi_nxt;
  logic [WIDTH-1:0] mul_lo_nxt;
  logic             mul_last;
  logic             mul_fin;
  logic [15:0]      mul_sr_out;

  // Add the multiplicand when the current multiplier LSB is set, then
  // shift the {carry, hi, lo} chain right by one.
  assign mul_add    = {1'b0, mul_hi} + {1'b0, mul_x & {WIDTH{mul_lo[0]}}};
  assign mul_hi_nxt = mul_add[WIDTH:1];
  assign mul_lo_nxt = {mul_add[0], mul_lo[WIDTH-1:1]};
  assign mul_last   = (mul_cnt == CNT_W'(WIDTH - 1));
  assign mul_fin    = (state == ST_MUL) && mul_last;

  // Product flags, computed from the final iteration's outputs.
  always_comb begin
    mul_sr_out       = mul_sr;
    mul_sr_out[SR_V] = 1'b0;
    mul_sr_out[SR_N] = mul_hi_nxt[WIDTH-1];
    mul_sr_out[SR_Z] = ({mul_hi_nxt, mul_lo_nxt} == '0);
    mul_sr_out[SR_C] = (mul_hi_nxt != '0);
  end

  // Multiplier operand capture, iteration and counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mul_x   <= '0;
      mul_hi  <= '0;
      mul_lo  <= '0;
      mul_sr  <= '0;
      mul_cnt <= '0;
    end else if (mul_load) begin
      mul_x   <= OP_X;
      mul_hi  <= '0;
      mul_lo  <= OP_Y;
      mul_sr  <= SR_IN;
      mul_cnt <= '0;
    end else if (state == ST_MUL) begin
      mul_hi  <= mul_hi_nxt;
      mul_lo  <= mul_lo_nxt;
      mul_cnt <= mul_last ? '0 : mul_cnt + CNT_W'(1);
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------

  // State register; reset dominates any request.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: requests are taken in IDLE and DONE only.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (!START)        state_nxt = ST_IDLE;
`ifdef ALU_MC_MUL_EN
        else if (mul_load) state_nxt = ST_MUL;
`endif
        else               state_nxt = ST_DONE;
      end
`ifdef ALU_MC_MUL_EN
      ST_MUL: if (mul_last) state_nxt = ST_DONE;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign DONE = (state == ST_DONE);
`ifdef ALU_MC_MUL_EN
  assign BUSY = (state == ST_MUL);
`else
  assign BUSY = 1'b0;
`endif

  // Result registers: hold until the next completing operation writes them.
  always_ff @(posedge CLK) begin
    if (RST) begin
      DATA_OUT <= '0;
      RES_HI   <= '0;
      SR_OUT   <= '0;
    end else if (alu_load) begin
      DATA_OUT <= alu_out;
      RES_HI   <= '0;
      SR_OUT   <= alu_sr;
    end
`ifdef ALU_MC_MUL_EN
    else if (mul_fin) begin
      DATA_OUT <= mul_lo_nxt;
      RES_HI   <= mul_hi_nxt;
      SR_OUT   <= mul_sr_out;
    end
`endif
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc at WIDTH=16.
// Expected results are pushed to a scoreboard when a request is driven and
// popped when the DUT pulses DONE. Covers both builds (ALU_MC_MUL_EN on/off).

module tb_alu_mc;

  localparam int W = 16;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic [3:0]    OP;
  logic [W-1:0]  OP_X;
  logic [W-1:0]  OP_Y;
  logic [15:0]   SR_IN;
  logic          BUSY;
  logic          DONE;
  logic [W-1:0]  DATA_OUT;
  logic [W-1:0]  RES_HI;
  logic [15:0]   SR_OUT;

  typedef struct {
    logic [15:0] data;
    logic [15:0] hi;
    logic [15:0] sr;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  alu_mc #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (START),
    .OP       (OP),
    .OP_X     (OP_X),
    .OP_Y     (OP_Y),
    .SR_IN    (SR_IN),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .DATA_OUT (DATA_OUT),
    .RES_HI   (RES_HI),
    .SR_OUT   (SR_OUT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $fatal(1, "FAIL watchdog: simulation did not finish in time");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] sr);
    START = 1'b1;
    OP    = op;
    OP_X  = x;
    OP_Y  = y;
    SR_IN = sr;
  endtask

  // Wait (bounded) for DONE; returns the cycle count since the request edge.
  task automatic wait_done(input string tag, input int budget, output int lat,
                           output int busy_cycles);
    bit seen;
    seen        = 1'b0;
    lat         = 0;
    busy_cycles = 0;
    for (int i = 1; i <= budget && !seen; i++) begin
      @(negedge CLK);
      if (i == 1) START = 1'b0;
      if (BUSY === 1'b1) busy_cycles++;
      if (DONE === 1'b1) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic pop_compare(input string tag);
    exp_t e;
    check({tag, "_sb_pending"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_data"}, 32'(DATA_OUT), 32'(e.data));
      check({tag, "_hi"},   32'(RES_HI),   32'(e.hi));
      check({tag, "_sr"},   32'(SR_OUT),   32'(e.sr));
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] x,
                        input logic [15:0] y, input logic [15:0] sr, input int exp_lat,
                        input logic [15:0] ed, input logic [15:0] eh, input logic [15:0] es);
    int lat, busy;
    drive(op, x, y, sr);
    sb.push_back('{data: ed, hi: eh, sr: es});
    wait_done(tag, exp_lat + 5, lat, busy);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    pop_compare(tag);
  endtask

  initial begin : stim
    int lat, busy, extra;

    RST   = 1'b1;
    START = 1'b0;
    OP    = 4'h0;
    OP_X  = '0;
    OP_Y  = '0;
    SR_IN = '0;
    repeat (3) @(negedge CLK);

    // Reset state
    check("rst_busy", 32'(BUSY),     32'd0);
    check("rst_done", 32'(DONE),     32'd0);
    check("rst_data", 32'(DATA_OUT), 32'd0);
    check("rst_hi",   32'(RES_HI),   32'd0);
    check("rst_sr",   32'(SR_OUT),   32'd0);
    RST = 1'b0;
    @(negedge CLK);

    // Single-cycle ops; consecutive calls also exercise accept-in-DONE.
    run_op("add_ovf", 4'h5, 16'h7FFF, 16'h0001, 16'h0000, 1, 16'h8000, 16'h0, 16'h0104);
    run_op("sub_eq",  4'h8, 16'h0001, 16'h0001, 16'h0000, 1, 16'h0000, 16'h0, 16'h0003);
    run_op("cmp_eq",  4'h9, 16'h0001, 16'h0001, 16'h0000, 1, 16'h0001, 16'h0, 16'h0003);
    run_op("rrc",     4'h0, 16'h0000, 16'h0002, 16'hF0F1, 1, 16'h8001, 16'h0, 16'hF0F4);
    run_op("rra",     4'h1, 16'h0000, 16'h8003, 16'h0000, 1, 16'hC001, 16'h0, 16'h0005);
    run_op("mov",     4'h4, 16'h1234, 16'h0000, 16'h0107, 1, 16'h1234, 16'h0, 16'h0107);

    // Results hold while idle
    repeat (3) @(negedge CLK);
    check("hold_data", 32'(DATA_OUT), 32'h1234);
    check("hold_sr",   32'(SR_OUT),   32'h0107);
    check("hold_done", 32'(DONE),     32'd0);

    run_op("bic",     4'hC, 16'h00FF, 16'h1234, 16'h0102, 1, 16'h1200, 16'h0, 16'h0102);
    run_op("bis",     4'hD, 16'h00F0, 16'h1204, 16'h0000, 1, 16'h12F4, 16'h0, 16'h0000);
    run_op("addc",    4'h6, 16'hFFFF, 16'h0000, 16'h0001, 1, 16'h0000, 16'h0, 16'h0003);
    run_op("subc",    4'h7, 16'h0001, 16'h0000, 16'h0000, 1, 16'hFFFE, 16'h0, 16'h0004);
    run_op("sub_ovf", 4'h8, 16'h0001, 16'h8000, 16'h0000, 1, 16'h7FFF, 16'h0, 16'h0101);
    run_op("xor_v",   4'hE, 16'h8001, 16'h8001, 16'h0000, 1, 16'h0000, 16'h0, 16'h0102);
    run_op("xor_c",   4'hE, 16'h8000, 16'h0001, 16'h0000, 1, 16'h8001, 16'h0, 16'h0005);
    run_op("and_z",   4'hF, 16'hF0F0, 16'h0F0F, 16'h0105, 1, 16'h0000, 16'h0, 16'h0002);
    run_op("bit",     4'hB, 16'h8080, 16'h80FF, 16'h0000, 1, 16'h80FF, 16'h0, 16'h0005);
    run_op("op2",     4'h2, 16'h0005, 16'h0006, 16'h0107, 1, 16'h0000, 16'h0, 16'h0107);
    run_op("op3",     4'h3, 16'h0005, 16'h0006, 16'hABCD, 1, 16'h0000, 16'h0, 16'hABCD);

`ifdef ALU_MC_MUL_EN
    // MUL 0xFFFF*0xFFFF with a START injected while BUSY
    drive(4'hA, 16'hFFFF, 16'hFFFF, 16'h0000);
    sb.push_back('{data: 16'h0001, hi: 16'hFFFE, sr: 16'h0005});
    lat  = 0;
    busy = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(negedge CLK);
      if (i == 1) START = 1'b0;
      if (i == 3) drive(4'h5, 16'h0001, 16'h0001, 16'h0000);
      if (i == 4) START = 1'b0;
      if (BUSY === 1'b1) busy++;
      if (DONE === 1'b1) lat = i;
    end
    check("mul_latency", 32'(lat),  32'd17);
    check("mul_busy",    32'(busy), 32'd16);
    pop_compare("mul_ffff");
    extra = 0;
    repeat (4) begin
      @(negedge CLK);
      if (DONE === 1'b1) extra++;
    end
    check("mul_ignored_start", 32'(extra),    32'd0);
    check("mul_hold_data",     32'(DATA_OUT), 32'h0001);

    run_op("mul_2",    4'hA, 16'h1234, 16'h0010, 16'h8000, 17, 16'h2340, 16'h0001, 16'h8001);
    run_op("mul_zero", 4'hA, 16'h0000, 16'h0005, 16'h0107, 17, 16'h0000, 16'h0000, 16'h0002);

    // Reset in the 5th MUL cycle aborts without a DONE pulse
    drive(4'hA, 16'h1234, 16'h0010, 16'h0000);
    for (int i = 1; i <= 5; i++) begin
      @(negedge CLK);
      if (i == 1) START = 1'b0;
    end
    check("abort_busy_before", 32'(BUSY), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("abort_busy", 32'(BUSY),     32'd0);
    check("abort_done", 32'(DONE),     32'd0);
    check("abort_data", 32'(DATA_OUT), 32'd0);
    check("abort_hi",   32'(RES_HI),   32'd0);
    check("abort_sr",   32'(SR_OUT),   32'd0);
    extra = 0;
    repeat (20) begin
      @(negedge CLK);
      if (DONE === 1'b1) extra++;
    end
    check("abort_no_done", 32'(extra), 32'd0);
`else
    // Without the multiplier, MUL is a one-cycle reserved op and BUSY stays low
    drive(4'hA, 16'hFFFF, 16'hFFFF, 16'h0107);
    sb.push_back('{data: 16'h0000, hi: 16'h0000, sr: 16'h0107});
    wait_done("mul_off", 20, lat, busy);
    check("mul_off_latency", 32'(lat),  32'd1);
    check("mul_off_busy",    32'(busy), 32'd0);
    pop_compare("mul_off");
`endif

    run_op("add_pre", 4'h5, 16'h0003, 16'h0004, 16'hF000, 1, 16'h0007, 16'h0, 16'hF000);

    // Reset dominates a simultaneous START
    drive(4'h5, 16'h7FFF, 16'h0001, 16'h0000);
    RST = 1'b1;
    @(negedge CLK);
    RST   = 1'b0;
    START = 1'b0;
    check("rst_dom_done", 32'(DONE),     32'd0);
    check("rst_dom_data", 32'(DATA_OUT), 32'd0);
    check("rst_dom_sr",   32'(SR_OUT),   32'd0);
    extra = 0;
    repeat (3) begin
      @(negedge CLK);
      if (DONE === 1'b1) extra++;
    end
    check("rst_dom_no_done", 32'(extra), 32'd0);

    run_op("add_after", 4'h5, 16'h0001, 16'hFFFF, 16'h0000, 1, 16'h0000, 16'h0, 16'h0003);

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (legal 8..32).
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port START  input  1  request; sampled only when BUSY=0.
REQ-005 SHALL have port OP  input  4  opcode, latched on accept.
REQ-006 SHALL have ports OP_X, OP_Y  input  WIDTH  source/destination operands, latched on accept.
REQ-007 SHALL have port SR_IN  input  16  status in: V=bit8, N=bit2, Z=bit1, C=bit0; latched on accept.
REQ-008 SHALL have port BUSY  output  1  high while a multiply iterates.
REQ-009 SHALL have port DONE  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports DATA_OUT  output  WIDTH  result; RES_HI  output  WIDTH  product high half, else 0.
REQ-011 SHALL have port SR_OUT  output  16  status out; bits other than V,N,Z,C copied from latched SR_IN.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DONE; START accepted in IDLE or DONE.
REQ-013 Non-MUL op SHALL go accept -> DONE; DONE=1 and results valid in the cycle after the accepting edge (latency 1).
REQ-014 MUL SHALL go accept -> MUL for exactly WIDTH cycles (BUSY=1) -> DONE; DONE asserted WIDTH+1 cycles after accept.
REQ-015 DONE state SHALL last one cycle, then IDLE unless a new START is accepted there.
REQ-016 START while BUSY=1 SHALL be ignored, no side effects.
REQ-017 DATA_OUT, RES_HI, SR_OUT SHALL hold last values until the next DONE.
REQ-018 Opcodes: 0x0 RRC {C,Y[W-1:1]}, C=Y[0]; 0x1 RRA {Y[W-1],Y[W-1:1]}, C=Y[0]; both N,Z from result, V=0.
REQ-019 0x4 MOV result=X, flags unchanged; 0xC BIC ~X&Y; 0xD BIS X|Y; both flags unchanged.
REQ-020 0x5 ADD X+Y; 0x6 ADDC X+Y+C; 0x7 SUBC Y+~X+C; 0x8 SUB Y-X (Y+~X+1); 0x9 CMP as SUB but DATA_OUT=Y.
REQ-021 Arithmetic flags: C = carry out of bit W-1; V = signed overflow of bit W-1; N = result[W-1]; Z = (result==0).
REQ-022 0xE XOR X^Y: V=X[W-1]&Y[W-1], N, Z, C=~Z; 0xF AND X&Y: V=0, N, Z, C=~Z; 0xB BIT as AND but DATA_OUT=Y.
REQ-023 0xA MUL: unsigned shift-add, one partial product per MUL cycle; {RES_HI,DATA_OUT}=X*Y (2W bits).
REQ-024 MUL flags: Z = full product zero, N = product[2W-1], C = (RES_HI!=0), V=0.
REQ-025 Opcodes 0x2, 0x3 SHALL complete in 1 cycle with DATA_OUT=0, RES_HI=0, SR_OUT=SR_IN.
REQ-026 Simultaneous START in DONE state SHALL be accepted; DONE pulse of prior op still emitted that cycle.

Reset
REQ-027 RST=1 at a clock edge SHALL force IDLE, BUSY=0, DONE=0, DATA_OUT=0, RES_HI=0, SR_OUT=0, counter=0.
REQ-028 RST SHALL dominate START; RST mid-MUL SHALL abort with no DONE pulse.

Configuration
REQ-029 Macro ALU_MC_MUL_EN SHALL compile in the multiplier datapath, counter and MUL state.
REQ-030 Without ALU_MC_MUL_EN, opcode 0xA SHALL behave as REQ-025 and BUSY SHALL be constant 0.

Verification (WIDTH=16)
REQ-031 ADD X=0x7FFF Y=0x0001 SR_IN=0 -> DONE next cycle, DATA_OUT=0x8000, SR_OUT V=1 N=1 Z=0 C=0.
REQ-032 SUB X=0x0001 Y=0x0001 -> DATA_OUT=0x0000, Z=1 C=1 N=0 V=0; CMP same -> DATA_OUT=0x0001, same flags.
REQ-033 RRC Y=0x0002 SR_IN C=1 -> DATA_OUT=0x8001, C=0 N=1 Z=0 V=0.
REQ-034 MUL X=0xFFFF Y=0xFFFF (MUL_EN) -> BUSY 16 cycles, DONE at accept+17, RES_HI=0xFFFE, DATA_OUT=0x0001, C=1; START during BUSY ignored.
REQ-035 MUL X=0x1234 Y=0x0010, RST at 5th MUL cycle -> next cycle all outputs 0, no DONE; subsequent ADD completes normally.
REQ-036 MUL without ALU_MC_MUL_EN, SR_IN=0x0107 -> DONE next cycle, DATA_OUT=0, RES_HI=0, SR_OUT=0x0107.
